// File: rtl/seq_mul_shift_unit_pkg.sv
// rtl/seq_mul_shift_unit_pkg.sv - shared opcodes, state encoding and width default
package seq_mul_shift_unit_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        OP_MUL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mul_shift_step.sv
// rtl/mul_shift_step.sv - one combinational iteration of multiply or shift/rotate
module mul_shift_step
    import seq_mul_shift_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  op_t                  op,
    input  logic [WIDTH-1:0]     value,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     b,
    input  logic [CNT_W-1:0]     idx,
    output logic [WIDTH-1:0]     value_next,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic [WIDTH-1:0]     b_next
);

    // Multiply adds the shifted multiplicand when the current multiplier bit is set;
    // shifts and rotate only move the working value.
    always_comb begin
        value_next = value;
        acc_next   = acc;
        b_next     = b;
        case (op)
            OP_MUL: begin
                if (b[0]) begin
                    acc_next = acc + ({{WIDTH{1'b0}}, value} << idx);
                end
                b_next = b >> 1;
            end
            OP_SLL:  value_next = value << 1;
            OP_SRL:  value_next = value >> 1;
            OP_ROR:  value_next = {value[0], value[WIDTH-1:1]};
            default: value_next = value;
        endcase
    end

endmodule

// File: rtl/seq_mul_shift_unit.sv
// rtl/seq_mul_shift_unit.sv - bit-serial multiply / shift / rotate unit behind the register file
module seq_mul_shift_unit
    import seq_mul_shift_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OPCODE,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    state_t               state_q, state_d;
    op_t                  op_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     n_load;
    logic [CNT_W-1:0]     idx;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     result_q;
    logic                 ovf_q;
    logic [WIDTH-1:0]     value_next, b_next;
    logic [2*WIDTH-1:0]   acc_next;
    logic                 last_step;

    // Multiply iteration index counts up while the counter counts down.
    assign idx       = CNT_W'(WIDTH) - cnt_q;
    assign last_step = (cnt_q == CNT_W'(1));
    assign RESULT    = result_q;
    assign OVF       = ovf_q;

    mul_shift_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .op         (op_q),
        .value      (a_q),
        .acc        (acc_q),
        .b          (b_q),
        .idx        (idx),
        .value_next (value_next),
        .acc_next   (acc_next),
        .b_next     (b_next)
    );

    // Iteration count for a new request: logical shifts saturate at WIDTH, rotate wraps.
    always_comb begin
        n_load = '0;
        case (op_t'(OPCODE))
            OP_MUL:         n_load = CNT_W'(WIDTH);
            OP_SLL, OP_SRL: n_load = (DATA2[3:0] > 4'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(DATA2[3:0]);
            OP_ROR:         n_load = CNT_W'(DATA2[2:0]);
            default:        n_load = '0;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; a zero-length request skips RUN entirely.
    always_comb begin
        state_d = state_q;
        BUSY    = 1'b0;
        DONE    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = (n_load == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                BUSY = 1'b1;
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                BUSY    = 1'b1;
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, per-bit iteration and result publication on the final step only.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        op_q  <= op_t'(OPCODE);
                        a_q   <= DATA1;
                        b_q   <= DATA2;
                        acc_q <= '0;
                        cnt_q <= n_load;
                        if (n_load == '0) begin
                            result_q <= DATA1;
                            ovf_q    <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    a_q   <= value_next;
                    acc_q <= acc_next;
                    b_q   <= b_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (last_step) begin
                        if (op_q == OP_MUL) begin
                            result_q <= acc_next[WIDTH-1:0];
                            ovf_q    <= |acc_next[2*WIDTH-1:WIDTH];
                        end else begin
                            result_q <= value_next;
                            ovf_q    <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_shift_unit.sv
// tb/tb_seq_mul_shift_unit.sv - directed self-checking bench for seq_mul_shift_unit
module tb_seq_mul_shift_unit;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [1:0] OPCODE;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       OVF;
    logic       BUSY;
    logic       DONE;

    int tests;
    int failures;

    seq_mul_shift_unit #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .OPCODE (OPCODE),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .OVF    (OVF),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and wait for DONE; lat counts BUSY cycles up to and including DONE.
    task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge CLK);
        START = 1'b1; OPCODE = op; DATA1 = a; DATA2 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        lat = 1;
        while (!DONE && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [1:0] op, input logic [7:0] a,
                             input logic [7:0] b, input logic [7:0] exp_res,
                             input logic exp_ovf, input int exp_lat);
        int lat;
        do_op(op, a, b, lat);
        check({tag, "_lat"},  16'(lat), 16'(exp_lat));
        check({tag, "_done"}, 16'(DONE), 16'd1);
        check({tag, "_res"},  16'(RESULT), 16'(exp_res));
        check({tag, "_ovf"},  16'(OVF), 16'(exp_ovf));
        @(posedge CLK); #1;
        check({tag, "_idle"}, {15'd0, BUSY | DONE}, 16'd0);
    endtask

    initial begin
        int pulses;
        logic [7:0] got;
        tests = 0; failures = 0;
        RESET = 1'b1; START = 1'b0; OPCODE = 2'b00; DATA1 = 8'h00; DATA2 = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", 16'(RESULT), 16'h0000);
        check("rst_ovf",    16'(OVF),    16'd0);
        check("rst_busy",   16'(BUSY),   16'd0);
        check("rst_done",   16'(DONE),   16'd0);
        @(negedge CLK); RESET = 1'b0;

        run_check("mul_13x11", 2'b00, 8'd13, 8'd11, 8'h8F, 1'b0, 9);
        run_check("mul_20x15", 2'b00, 8'd20, 8'd15, 8'h2C, 1'b1, 9);

        // Operands change while idle; published result must hold.
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            DATA1 = 8'hA5 ^ 8'(i); DATA2 = 8'h3C + 8'(i);
        end
        @(posedge CLK); #1;
        check("hold_res",  16'(RESULT), 16'h002C);
        check("hold_ovf",  16'(OVF),    16'd1);
        check("hold_busy", 16'(BUSY),   16'd0);

        run_check("sll_81_3", 2'b01, 8'h81, 8'd3, 8'h08, 1'b0, 4);
        run_check("srl_81_9", 2'b10, 8'h81, 8'd9, 8'h00, 1'b0, 9);
        run_check("ror_81_1", 2'b11, 8'h81, 8'd1, 8'hC0, 1'b0, 2);
        run_check("ror_81_8", 2'b11, 8'h81, 8'd8, 8'h81, 1'b0, 1);
        run_check("sll_hi_nib", 2'b01, 8'h03, 8'hF2, 8'h0C, 1'b0, 3);

        // START while busy is dropped.
        @(negedge CLK);
        START = 1'b1; OPCODE = 2'b00; DATA1 = 8'd3; DATA2 = 8'd5;
        @(posedge CLK); #1;
        START = 1'b0;
        pulses = 0; got = 8'h00;
        for (int c = 0; c < 14; c++) begin
            if (c == 2) begin START = 1'b1; OPCODE = 2'b01; DATA1 = 8'hFF; DATA2 = 8'h01; end
            if (c == 4) START = 1'b0;
            @(posedge CLK); #1;
            if (DONE) begin pulses++; got = RESULT; end
        end
        check("busy_pulses", 16'(pulses), 16'd1);
        check("busy_res",    16'(got),    16'h000F);
        run_check("after_busy", 2'b01, 8'h05, 8'd1, 8'h0A, 1'b0, 2);

        // Asynchronous reset in the middle of a multiply.
        @(negedge CLK);
        START = 1'b1; OPCODE = 2'b00; DATA1 = 8'd200; DATA2 = 8'd2;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("arst_result", 16'(RESULT), 16'h0000);
        check("arst_ovf",    16'(OVF),    16'd0);
        check("arst_busy",   16'(BUSY),   16'd0);
        check("arst_done",   16'(DONE),   16'd0);
        @(posedge CLK);
        @(negedge CLK); RESET = 1'b0;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge CLK); #1;
            if (DONE) pulses++;
        end
        check("arst_no_done", 16'(pulses), 16'd0);
        run_check("mul_6x7", 2'b00, 8'd6, 8'd7, 8'h2A, 1'b0, 9);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
